// File: rtl/aes_round_sequencer.sv
// Round-level controller for one AES encryption. It holds the 128-bit state and the round counter,
// fetches round keys over a req/ack handshake, and steps the external combinational round datapath.
module aes_round_sequencer #(
  parameter int NR    = 10,
  parameter int CNT_W = 4
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [127:0]     in_block_i,
  output logic             key_req_o,
  output logic [CNT_W-1:0] key_idx_o,
  input  logic             key_ack_i,
  input  logic [127:0]     key_in_i,
  output logic [127:0]     dp_state_o,
  output logic             dp_final_o,
  input  logic [127:0]     dp_result_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [127:0]     out_block_o,
  output logic             busy_o
);

  typedef enum logic [1:0] {IDLE, ADDKEY, ROUND, DONE} fsm_t;

  localparam logic [CNT_W-1:0] LAST    = CNT_W'(NR);
  localparam logic [CNT_W-1:0] LAST_M1 = CNT_W'(NR - 1);

  fsm_t             fsm_q;
  logic [127:0]     state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             in_ready_q, key_req_q, out_valid_q, dp_final_q, busy_q;

  // Handshake flags are updated alongside each transition so every output is a flop.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      fsm_q       <= IDLE;
      state_q     <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      key_req_q   <= 1'b0;
      out_valid_q <= 1'b0;
      dp_final_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (fsm_q)
        IDLE: if (in_valid_i) begin
          state_q    <= in_block_i;
          cnt_q      <= '0;
          fsm_q      <= ADDKEY;
          in_ready_q <= 1'b0;
          key_req_q  <= 1'b1;
          busy_q     <= 1'b1;
        end
        ADDKEY: if (key_ack_i) begin
          state_q   <= state_q ^ key_in_i;
          key_req_q <= 1'b0;
          if (cnt_q == LAST) begin
            fsm_q       <= DONE;
            out_valid_q <= 1'b1;
          end else begin
            cnt_q      <= cnt_q + CNT_W'(1);
            fsm_q      <= ROUND;
            // The round entered after key NR-1 is the last one: no mix columns.
            dp_final_q <= (cnt_q == LAST_M1);
          end
        end
        ROUND: begin
          state_q    <= dp_result_i;
          fsm_q      <= ADDKEY;
          key_req_q  <= 1'b1;
          dp_final_q <= 1'b0;
        end
        DONE: if (out_ready_i) begin
          fsm_q       <= IDLE;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          busy_q      <= 1'b0;
        end
        default: fsm_q <= IDLE;
      endcase
    end
  end

  assign in_ready_o  = in_ready_q;
  assign key_req_o   = key_req_q;
  assign key_idx_o   = cnt_q;
  assign dp_state_o  = state_q;
  assign dp_final_o  = dp_final_q;
  assign out_valid_o = out_valid_q;
  assign out_block_o = state_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Scoreboard bench: the bench models AES itself (the FIPS-197 algorithm) and also plays the role of
// the round datapath and the key schedule around the sequencer.
module tb_aes_round_sequencer;
  localparam int NR    = 10;
  localparam int CNT_W = 4;

  typedef logic [127:0] blk_t;
  typedef struct { blk_t blk; int e; int lat; } exp_t;

  logic             clk = 1'b0;
  logic             reset, in_valid, in_ready, key_req, key_ack, dp_final, out_valid, out_ready, busy;
  logic [CNT_W-1:0] key_idx;
  blk_t             in_block, key_in, dp_state, dp_result, out_block;

  always #5 clk = ~clk;

  aes_round_sequencer #(.NR(NR), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .reset_i(reset), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_block_i(in_block), .key_req_o(key_req), .key_idx_o(key_idx), .key_ack_i(key_ack),
    .key_in_i(key_in), .dp_state_o(dp_state), .dp_final_o(dp_final), .dp_result_i(dp_result),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_block_o(out_block), .busy_o(busy)
  );

  int   total = 0, bad = 0, cyc = 0;
  exp_t exp_q[$];
  logic [7:0] sb [256];
  blk_t nxt_rk [0:NR];
  blk_t cur_rk [0:NR];
  int   nxt_dly [0:NR];
  int   cur_dly [0:NR];
  int   nxt_ostall = 0, cur_ostall = 0;
  bit   nxt_stub = 0, stub = 0, nxt_kat_en = 0, stray_en = 0;
  blk_t nxt_kat;
  int   last_e = 0, last_gap = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- AES reference ----------------
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xt(a);
      b = b >> 1;
    end
    return p;
  endfunction

  task automatic init_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] v = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) v = 8'(y);
      sb[x] = v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
    end
  endtask

  // byte i of the block is bits [127-8i -: 8]; state is column-major (row = i%4, col = i/4)
  function automatic blk_t aes_round(input blk_t st, input logic fin);
    logic [7:0] b [16];
    logic [7:0] s [16];
    logic [7:0] o [16];
    blk_t r;
    for (int i = 0; i < 16; i++) b[i] = sb[st[127-8*i -: 8]];
    for (int c = 0; c < 4; c++)
      for (int w = 0; w < 4; w++) s[w + 4*c] = b[w + 4*((c + w) % 4)];
    for (int c = 0; c < 4; c++) begin
      logic [7:0] a0, a1, a2, a3;
      a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
      o[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
      o[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
      o[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
      o[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
    end
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = fin ? s[i] : o[i];
    return r;
  endfunction

  task automatic load_keys(input blk_t key);
    logic [31:0] w [0:4*NR+3];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 4*NR+4; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int k = 0; k <= NR; k++) nxt_rk[k] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
  endtask

  // Whole-encryption model: whitening key, then NR rounds each followed by its round key.
  function automatic blk_t model(input blk_t pt);
    blk_t st = pt ^ cur_rk[0];
    for (int r = 1; r <= NR; r++)
      st = (stub ? ~st : aes_round(st, r == NR)) ^ cur_rk[r];
    return st;
  endfunction

  assign dp_result = stub ? ~dp_state : aes_round(dp_state, dp_final);

  task automatic chk(input string nm, input blk_t act, input blk_t want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, want);
    end
  endtask

  // ---------------- key schedule responder ----------------
  initial begin
    int kcnt = 0;
    key_ack = 1'b0;
    key_in  = '0;
    forever begin
      int idx;
      @(negedge clk);
      if (key_req) begin
        idx = int'(key_idx);
        if (idx > NR) idx = 0;
        if (kcnt >= cur_dly[idx]) begin
          key_ack = 1'b1;
          key_in  = cur_rk[idx];
        end else begin
          key_ack = 1'b0;
          key_in  = {$urandom, $urandom, $urandom, $urandom};
          kcnt++;
        end
      end else begin
        kcnt    = 0;
        key_ack = stray_en && ($urandom_range(0, 1) == 1);
        key_in  = {$urandom, $urandom, $urandom, $urandom};
      end
    end
  end

  // ---------------- downstream sink ----------------
  initial begin
    int ocnt = 0;
    out_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (out_valid) begin
        if (ocnt < cur_ostall) begin
          out_ready = 1'b0;
          ocnt++;
        end else out_ready = 1'b1;
      end else begin
        ocnt      = 0;
        out_ready = ($urandom_range(0, 1) == 1);
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin
    int   idxs[$];
    int   fcnt = 0;
    bit   seen = 0;
    blk_t held = '0;
    exp_t e;
    blk_t seq_act, seq_exp;
    seq_exp = '0;
    for (int k = 0; k <= NR; k++) seq_exp = (seq_exp << 4) | blk_t'(k);
    forever begin
      @(negedge clk);
      #3;
      if (reset) begin
        idxs.delete();
        fcnt = 0;
        seen = 0;
      end else begin
        if (key_req && key_ack) idxs.push_back(int'(key_idx));
        if (dp_final) fcnt++;
        if (out_valid) begin
          if (!seen) begin
            seen = 1;
            held = out_block;
            if (exp_q.size() == 0) begin
              total++; bad++;
              $display("FAIL unexpected_output: got %h want no output", out_block);
            end else begin
              e = exp_q.pop_front();
              chk("out_block", out_block, e.blk);
              chk("latency", blk_t'(cyc - e.e), blk_t'(e.lat));
              seq_act = '0;
              foreach (idxs[k]) seq_act = (seq_act << 4) | blk_t'(idxs[k] & 15);
              chk("key_idx_seq", seq_act, seq_exp);
              chk("dp_final_cycles", blk_t'(fcnt), blk_t'(1));
            end
            idxs.delete();
            fcnt = 0;
          end else begin
            chk("out_block_stable", out_block, held);
            chk("in_ready_in_done", blk_t'(in_ready), blk_t'(0));
          end
          if (out_ready) seen = 0;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(input blk_t pt, input bit chk_gap);
    int   n = 0;
    int   sum = 0;
    exp_t e;
    @(negedge clk);
    in_valid = 1'b1;
    in_block = pt;
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      total++; bad++;
      $display("FAIL accept_timeout: in_ready got 0 want 1");
      in_valid = 1'b0;
      return;
    end
    cur_rk = nxt_rk; cur_dly = nxt_dly; cur_ostall = nxt_ostall; stub = nxt_stub;
    foreach (cur_dly[k]) sum += cur_dly[k];
    e.e   = cyc + 1;
    e.lat = 2*NR + 1 + sum;
    e.blk = nxt_kat_en ? nxt_kat : model(pt);
    if (chk_gap) chk("accept_gap", blk_t'(e.e - last_e), blk_t'(last_gap));
    last_e   = e.e;
    last_gap = e.lat + cur_ostall + 2;
    exp_q.push_back(e);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic plain_cfg();
    foreach (nxt_dly[k]) nxt_dly[k] = 0;
    nxt_ostall = 0; nxt_stub = 0; nxt_kat_en = 0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      total++; bad++;
      $display("FAIL drain_timeout: pending got %0d want 0", exp_q.size());
      exp_q.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int n;
    reset = 1'b1; in_valid = 1'b0; in_block = '0;
    init_sbox();
    plain_cfg();
    repeat (3) @(negedge clk);
    #3;
    chk("rst_key_req", blk_t'(key_req), 0);
    chk("rst_out_valid", blk_t'(out_valid), 0);
    chk("rst_dp_final", blk_t'(dp_final), 0);
    chk("rst_busy", blk_t'(busy), 0);
    chk("rst_dp_state", dp_state, 0);
    @(negedge clk) reset = 1'b0;
    @(negedge clk) #3;
    chk("rst_in_ready", blk_t'(in_ready), 1);

    // FIPS-197 C.1 known answer through the real round function
    load_keys(128'h000102030405060708090a0b0c0d0e0f);
    nxt_kat_en = 1; nxt_kat = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    send(128'h00112233445566778899aabbccddeeff, 0);
    drain();

    // inverting stub datapath with zero keys is an identity over an even round count
    plain_cfg();
    nxt_stub = 1;
    foreach (nxt_rk[k]) nxt_rk[k] = '0;
    send({$urandom, $urandom, $urandom, $urandom}, 0);
    drain();

    // withheld ack on key 5
    plain_cfg();
    load_keys({$urandom, $urandom, $urandom, $urandom});
    nxt_dly[5] = 3;
    send({$urandom, $urandom, $urandom, $urandom}, 0);
    drain();

    // DONE stall with the next block already waiting on in_valid
    plain_cfg();
    nxt_ostall = 5;
    send({$urandom, $urandom, $urandom, $urandom}, 0);
    plain_cfg();
    send({$urandom, $urandom, $urandom, $urandom}, 1);
    drain();

    // reset while the counter sits at 4 in ROUND
    plain_cfg();
    send({$urandom, $urandom, $urandom, $urandom}, 0);
    n = 0;
    do begin
      @(negedge clk);
      #3;
      n++;
    end while (!(key_req && key_ack && key_idx == CNT_W'(3)) && n < 100);
    chk("reach_idx3", blk_t'(n < 100), 1);
    @(negedge clk) reset = 1'b1;
    @(negedge clk) reset = 1'b0;
    exp_q.delete();
    #3;
    chk("midrst_key_req", blk_t'(key_req), 0);
    chk("midrst_out_valid", blk_t'(out_valid), 0);
    chk("midrst_in_ready", blk_t'(in_ready), 1);
    chk("midrst_busy", blk_t'(busy), 0);
    chk("midrst_dp_state", dp_state, 0);
    send({$urandom, $urandom, $urandom, $urandom}, 0);
    drain();

    // randomized back-to-back traffic with stray acks
    stray_en = 1;
    for (int b = 0; b < 12; b++) begin
      plain_cfg();
      load_keys({$urandom, $urandom, $urandom, $urandom});
      nxt_stub = ($urandom_range(0, 3) == 0);
      foreach (nxt_dly[k]) nxt_dly[k] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      nxt_ostall = $urandom_range(0, 3);
      send({$urandom, $urandom, $urandom, $urandom}, b != 0);
    end
    drain();

    // all handshakes immediate: accepts 2*NR+3 apart
    for (int b = 0; b < 3; b++) begin
      plain_cfg();
      load_keys({$urandom, $urandom, $urandom, $urandom});
      send({$urandom, $urandom, $urandom, $urandom}, b != 0);
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation got stuck want completion");
    $fatal(1, "watchdog");
  end

endmodule
